// File: rtl/eeprom_pkg.sv
// Shared types and helpers for the paged EEPROM: FSM states, strobe decode
// and the DATA-polling word used while a page is being programmed.
package eeprom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PROGRAM
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP,
    CMD_RD,
    CMD_WR
  } cmd_e;

  localparam int POLL_MAX_W = 64;

  // Both oe_n and we_n low is deliberately a no-op, as is any deselected cycle.
  function automatic cmd_e cmd_decode(input logic ce_n, input logic oe_n,
                                      input logic we_n);
    cmd_e c;
    c = CMD_NOP;
    if (!ce_n && !oe_n && we_n) c = CMD_RD;
    else if (!ce_n && oe_n && !we_n) c = CMD_WR;
    return c;
  endfunction

  // Polling returns the complement of the last written MSB with all other bits 0.
  function automatic logic [POLL_MAX_W-1:0] poll_word(input logic msb,
                                                      input int unsigned w);
    logic [POLL_MAX_W-1:0] r;
    r = '0;
    r[w-1] = ~msb;
    return r;
  endfunction

endpackage

// File: rtl/eeprom_page_buf.sv
// Page staging buffer: one register per page slot plus a valid mask that
// records which slots must be committed at the end of the window.
module eeprom_page_buf #(
  parameter int DATA_W = 8,
  parameter int PAGE_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr,
  input  logic [PAGE_W-1:0]              slot,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           clr,
  output logic [(2**PAGE_W)*DATA_W-1:0]  data,
  output logic [2**PAGE_W-1:0]           valid
);

  localparam int PAGE_SIZE = 2**PAGE_W;

  logic [DATA_W-1:0] slots [PAGE_SIZE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (clr) valid <= '0;
    else if (wr) valid[slot] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr) slots[slot] <= wdata;
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < PAGE_SIZE; i++) data[i*DATA_W +: DATA_W] = slots[i];
  end

endmodule

// File: rtl/eeprom_paged.sv
// Synchronous paged EEPROM: page-write buffering, timed programming cycle
// with ready/busy, and AT28C16-style DATA polling on reads while busy.
module eeprom_paged
  import eeprom_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 11,
  parameter int PAGE_W       = 4,
  parameter int PAGE_WINDOW  = 8,
  parameter int WRITE_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_n,
  input  logic              oe_n,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              ready,
  output logic              err
);

  localparam int PAGE_SIZE = 2**PAGE_W;
  localparam int WIN_CW    = $clog2(PAGE_WINDOW) + 1;
  localparam int PROG_CW   = $clog2(WRITE_CYCLES) + 1;

  state_e state, state_nxt;
  cmd_e   cmd;

  logic [WIN_CW-1:0]         win_cnt;
  logic [PROG_CW-1:0]        prog_cnt;
  logic [ADDR_W-PAGE_W-1:0]  page_addr;
  logic                      last_msb;
  logic                      buf_wr, win_load, commit, rd_mem, rd_poll, drop;
  logic                      same_page;
  logic [PAGE_SIZE*DATA_W-1:0] buf_data;
  logic [PAGE_SIZE-1:0]      buf_valid;
  logic [DATA_W-1:0]         mem [2**ADDR_W];

  assign cmd       = cmd_decode(ce_n, oe_n, we_n);
  assign same_page = (addr[ADDR_W-1:PAGE_W] == page_addr);
  assign ready     = (state != ST_PROGRAM);

  eeprom_page_buf #(.DATA_W(DATA_W), .PAGE_W(PAGE_W)) u_page_buf (
    .clk   (clk),
    .rst   (rst),
    .wr    (buf_wr),
    .slot  (addr[PAGE_W-1:0]),
    .wdata (wdata),
    .clr   (commit),
    .data  (buf_data),
    .valid (buf_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    buf_wr    = 1'b0;
    win_load  = 1'b0;
    commit    = 1'b0;
    rd_mem    = 1'b0;
    rd_poll   = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd == CMD_RD) rd_mem = 1'b1;
        else if (cmd == CMD_WR) begin
          buf_wr    = 1'b1;
          win_load  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cmd == CMD_WR) begin
          if (same_page) begin
            buf_wr   = 1'b1;
            win_load = 1'b1;
          end else begin
            drop      = 1'b1;
            state_nxt = ST_PROGRAM;
          end
        end else if (cmd == CMD_RD) begin
          rd_poll   = 1'b1;
          state_nxt = ST_PROGRAM;
        end else if (win_cnt == WIN_CW'(1)) begin
          state_nxt = ST_PROGRAM;
        end
      end
      ST_PROGRAM: begin
        if (cmd == CMD_RD) rd_poll = 1'b1;
        else if (cmd == CMD_WR) drop = 1'b1;
        if (prog_cnt == PROG_CW'(1)) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Window and programming counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt  <= '0;
      prog_cnt <= '0;
    end else begin
      if (win_load) win_cnt <= WIN_CW'(PAGE_WINDOW);
      else if (state == ST_LOAD) win_cnt <= win_cnt - WIN_CW'(1);
      if (state != ST_PROGRAM && state_nxt == ST_PROGRAM)
        prog_cnt <= PROG_CW'(WRITE_CYCLES);
      else if (state == ST_PROGRAM)
        prog_cnt <= prog_cnt - PROG_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr) begin
      page_addr <= addr[ADDR_W-1:PAGE_W];
      last_msb  <= wdata[DATA_W-1];
    end
  end

  // Commit the whole page in the final programming clock
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < PAGE_SIZE; i++)
        if (buf_valid[i]) mem[{page_addr, PAGE_W'(i)}] <= buf_data[i*DATA_W +: DATA_W];
    end
  end

  // Read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= rd_mem | rd_poll;
      err         <= drop;
      if (rd_mem) rdata <= mem[addr];
      else if (rd_poll) rdata <= DATA_W'(poll_word(last_msb, DATA_W));
    end
  end

endmodule

// File: tb/tb_eeprom_paged.sv
// Scoreboard bench for eeprom_paged: expected read data is queued when a read
// is issued and matched when rdata_valid appears.
module tb_eeprom_paged;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1;
  logic [10:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        rdata_valid, ready, err;

  int n_chk = 0, n_bad = 0;
  int err_cnt = 0, prog_entries = 0;
  logic prev_ready = 1'b1;
  logic [7:0] exp_q[$];

  eeprom_paged dut (
    .clk(clk), .rst(rst), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard pop, err pulses, busy entries
  always @(negedge clk) begin
    if (rdata_valid) begin
      if (exp_q.size() == 0) check_val("unexpected_rd", 32'd1, 32'd0);
      else check_val("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
    end
    if (err) err_cnt++;
    if (prev_ready && !ready) prog_entries++;
    prev_ready = ready;
  end

  task automatic do_nop(input int n);
    repeat (n) begin
      @(negedge clk);
      ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    end
  endtask

  task automatic do_wr(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0; addr = a; wdata = d;
  endtask

  task automatic do_rd(input logic [10:0] a, input logic [7:0] exp);
    @(negedge clk);
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = a;
    exp_q.push_back(exp);
  endtask

  task automatic wait_level(input logic lvl, input string tag);
    int n = 0;
    while (ready !== lvl && n < 100) begin
      do_nop(1);
      n++;
    end
    check_val(tag, {31'd0, ready}, {31'd0, lvl});
  endtask

  task automatic prog_word(input logic [10:0] a, input logic [7:0] d);
    do_wr(a, d);
    wait_level(1'b0, "preload_busy");
    wait_level(1'b1, "preload_done");
  endtask

  initial begin
    int hi, lo, e0, p0;
    logic seen_lo;

    do_nop(3);
    check_val("rst_ready", {31'd0, ready}, 32'd1);
    check_val("rst_rdata", {24'd0, rdata}, 32'd0);
    check_val("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // Known background contents
    prog_word(11'h123, 8'h5A);
    prog_word(11'h030, 8'hC3);
    prog_word(11'h050, 8'h5C);
    prog_word(11'h060, 8'h66);
    do_rd(11'h030, 8'hC3);
    do_nop(2);

    // Reset clears rdata but keeps memory
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_val("rst2_rdata", {24'd0, rdata}, 32'd0);
    do_rd(11'h123, 8'h5A);
    do_nop(1);
    check_val("rd_ready", {31'd0, ready}, 32'd1);
    do_nop(1);

    // Single write: window, busy length, polling
    do_wr(11'h010, 8'hA7);
    hi = 0; lo = 0; seen_lo = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 15) do_rd(11'h010, 8'h00);
      else do_nop(1);
      if (!ready) begin lo++; seen_lo = 1'b1; end
      else if (!seen_lo) hi++;
      else break;
    end
    check_val("window_len", hi, 32'd8);
    check_val("busy_len", lo, 32'd32);
    do_rd(11'h010, 8'hA7);
    do_nop(2);

    // Full page write, one program cycle, polling with MSB 0
    p0 = prog_entries;
    for (int i = 0; i < 16; i++) do_wr(11'h020 + 11'(i), 8'(i));
    do_nop(10);
    do_rd(11'h020, 8'h80);
    wait_level(1'b1, "page_done");
    check_val("page_prog_cnt", prog_entries - p0, 32'd1);
    for (int i = 0; i < 16; i++) do_rd(11'h020 + 11'(i), 8'(i));
    do_rd(11'h030, 8'hC3);
    do_nop(2);

    // Cross-page write is dropped and starts programming at once
    e0 = err_cnt;
    do_wr(11'h040, 8'h11);
    do_wr(11'h050, 8'h22);
    do_nop(1);
    check_val("xpage_err", {31'd0, err}, 32'd1);
    check_val("xpage_busy", {31'd0, ready}, 32'd0);
    wait_level(1'b1, "xpage_done");
    check_val("xpage_err_cnt", err_cnt - e0, 32'd1);
    do_rd(11'h040, 8'h11);
    do_rd(11'h050, 8'h5C);
    do_nop(2);

    // Write during programming is dropped
    prog_word(11'h070, 8'h77);
    do_wr(11'h070, 8'h12);
    do_nop(10);
    e0 = err_cnt;
    do_wr(11'h070, 8'h99);
    do_nop(1);
    check_val("busy_wr_err", {31'd0, err}, 32'd1);
    wait_level(1'b1, "busy_wr_done");
    check_val("busy_wr_err_cnt", err_cnt - e0, 32'd1);
    do_rd(11'h070, 8'h12);
    do_nop(2);

    // oe_n and we_n both low is a no-op
    @(negedge clk);
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0; addr = 11'h070; wdata = 8'h00;
    do_nop(1);
    check_val("conflict_rvalid", {31'd0, rdata_valid}, 32'd0);
    lo = 0;
    for (int i = 0; i < 12; i++) begin
      do_nop(1);
      if (!ready) lo++;
    end
    check_val("conflict_no_prog", lo, 32'd0);
    do_rd(11'h070, 8'h12);
    do_nop(2);

    // Async reset in the middle of programming
    do_wr(11'h060, 8'h33);
    do_nop(15);
    check_val("mid_prog_busy", {31'd0, ready}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_ready", {31'd0, ready}, 32'd1);
    check_val("async_rst_rdata", {24'd0, rdata}, 32'd0);
    @(negedge clk); rst = 1'b0;
    do_rd(11'h060, 8'h66);
    do_nop(3);
    check_val("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
